flex_counter_multi: RTL and testbench

//  Multi-channel up/down flex counter. NUM_CH independent counters share one clock and reset.

---
 rtl/flex_counter_pkg.sv | 15 +
 rtl/flex_counter_multi_if.sv | 38 +++
 rtl/flex_counter_ch.sv | 110 +++++++++++
 rtl/flex_counter_multi.sv | 46 ++++
 tb/tb_flex_counter_multi.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types and default sizes for the multi-channel flex counter.
// Contents:
//   cnt_dir_t    : count direction (up / down)
//   cnt_mode_t   : behaviour at the terminal value (wrap / saturate)
//   DEF_CNT_BITS : default width of one channel's count
//   DEF_NUM_CH   : default number of channels
package flex_counter_pkg;

    typedef enum logic {CNT_UP = 1'b0, CNT_DOWN = 1'b1} cnt_dir_t;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} cnt_mode_t;

    localparam int DEF_CNT_BITS = 8;
    localparam int DEF_NUM_CH   = 4;

endpackage

// File: rtl/flex_counter_multi_if.sv
// Bundle of per-channel control inputs and status outputs of flex_counter_multi.
// Multi-bit fields are packed [NUM_CH-1:0][NUM_CNT_BITS-1:0], so channel i is field [i].
// Modports:
//   master : drives clear/load/count_enable/count_down/saturate/load_val/rollover_val,
//            observes count_out/rollover_flag/wrap_pulse/any_wrap
//   slave  : the counter itself (mirror image of master)
// Handshake: there is no valid/ready pair. Every control input is sampled on every rising
// clk edge, and every output is valid in every cycle (count_out, rollover_flag and
// wrap_pulse are registered; any_wrap is their combinational reduction).
interface flex_counter_multi_if
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEF_CNT_BITS,
    parameter int NUM_CH       = DEF_NUM_CH
);
    logic [NUM_CH-1:0]                    clear;
    logic [NUM_CH-1:0]                    load;
    logic [NUM_CH-1:0]                    count_enable;
    logic [NUM_CH-1:0]                    count_down;
    logic [NUM_CH-1:0]                    saturate;
    logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  load_val;
    logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  rollover_val;
    logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  count_out;
    logic [NUM_CH-1:0]                    rollover_flag;
    logic [NUM_CH-1:0]                    wrap_pulse;
    logic                                 any_wrap;

    modport master (
        output clear, load, count_enable, count_down, saturate, load_val, rollover_val,
        input  count_out, rollover_flag, wrap_pulse, any_wrap
    );

    modport slave (
        input  clear, load, count_enable, count_down, saturate, load_val, rollover_val,
        output count_out, rollover_flag, wrap_pulse, any_wrap
    );

endinterface

// File: rtl/flex_counter_ch.sv
// One channel of the flex counter: next-count logic plus the count, rollover flag and
// wrap pulse registers.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : synchronous clear (highest priority)
//   load, load_val  : synchronous load, clamped to rollover_val
//   count_enable    : step the count by one in the selected direction
//   count_down      : 0 = up, 1 = down
//   saturate        : 0 = wrap at terminal, 1 = hold at terminal
//   rollover_val    : top count of this channel
//   count_out       : registered count
//   rollover_flag   : registered, count equals the terminal value
//   wrap_pulse      : registered one-cycle pulse after a wrap
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEF_CNT_BITS
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     count_enable,
    input  logic                     count_down,
    input  logic                     saturate,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     wrap_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;

    cnt_dir_t                 dir;
    cnt_mode_t                mode;
    logic [NUM_CNT_BITS-1:0]  next_count;
    logic [NUM_CNT_BITS-1:0]  terminal;
    logic                     next_wrap;
    logic                     next_flag;

    assign dir  = cnt_dir_t'(count_down);
    assign mode = cnt_mode_t'(saturate);

    // Terminal value follows the direction selected in this same cycle.
    assign terminal = (dir == CNT_DOWN) ? ZERO : rollover_val;

    always_comb begin
        next_count = count_out;
        next_wrap  = 1'b0;
        if (clear) begin
            next_count = ZERO;
        end else if (load) begin
            next_count = (load_val > rollover_val) ? rollover_val : load_val;
        end else if (count_enable) begin
            if (dir == CNT_UP) begin
                // >= rather than == so a count stranded above a lowered rollover_val
                // returns into range instead of running on to the natural overflow.
                if (count_out >= rollover_val) begin
                    if (mode == MODE_SAT) begin
                        next_count = rollover_val;
                    end else begin
                        next_count = ZERO;
                        next_wrap  = 1'b1;
                    end
                end else begin
                    next_count = count_out + ONE;
                end
            end else begin
                if (count_out == ZERO) begin
                    if (mode == MODE_SAT) begin
                        next_count = ZERO;
                    end else begin
                        next_count = rollover_val;
                        next_wrap  = 1'b1;
                    end
                end else if (count_out > rollover_val) begin
                    next_count = rollover_val;
                end else begin
                    next_count = count_out - ONE;
                end
            end
        end
    end

    // Flag only re-evaluates on activity; an idle channel keeps its last flag.
    always_comb begin
        next_flag = rollover_flag;
        if (clear) begin
            next_flag = 1'b0;
        end else if (load || count_enable) begin
            next_flag = (next_count == terminal);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= next_flag;
            wrap_pulse    <= next_wrap;
        end
    end

endmodule

// File: rtl/flex_counter_multi.sv
// Multi-channel up/down flex counter: NUM_CH independent channels sharing clk and rst.
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : flex_counter_multi_if slave modport carrying per-channel controls and status
module flex_counter_multi
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEF_CNT_BITS,
    parameter int NUM_CH       = DEF_NUM_CH
)
(
    input  logic                  clk,
    input  logic                  rst,
    flex_counter_multi_if.slave   bus
);

    logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  cnt_q;
    logic [NUM_CH-1:0]                    flag_q;
    logic [NUM_CH-1:0]                    wrap_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_ch #(
            .NUM_CNT_BITS (NUM_CNT_BITS)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .clear         (bus.clear[i]),
            .load          (bus.load[i]),
            .count_enable  (bus.count_enable[i]),
            .count_down    (bus.count_down[i]),
            .saturate      (bus.saturate[i]),
            .load_val      (bus.load_val[i]),
            .rollover_val  (bus.rollover_val[i]),
            .count_out     (cnt_q[i]),
            .rollover_flag (flag_q[i]),
            .wrap_pulse    (wrap_q[i])
        );
    end

    assign bus.count_out     = cnt_q;
    assign bus.rollover_flag = flag_q;
    assign bus.wrap_pulse    = wrap_q;
    assign bus.any_wrap      = |wrap_q;

endmodule

// File: tb/tb_flex_counter_multi.sv
// Directed bench for flex_counter_multi (4-bit count, 2 channels) plus a 1-channel instance
// whose channel 0 mirrors the main instance's channel 0, used to check any_wrap at NUM_CH=1.
// Each step drives all controls and pushes the hand-computed response; a monitor pops and
// compares on the falling edge after the rising edge that produced it.
module tb_flex_counter_multi;

    localparam int W     = 4;
    localparam int NCH   = 2;
    localparam int EXP_W = 14; // cnt[8] flg[2] wrp[2] any any1

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    flex_counter_multi_if #(.NUM_CNT_BITS(W), .NUM_CH(NCH)) bus ();
    flex_counter_multi_if #(.NUM_CNT_BITS(W), .NUM_CH(1))   bus1 ();

    flex_counter_multi #(.NUM_CNT_BITS(W), .NUM_CH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    flex_counter_multi #(.NUM_CNT_BITS(W), .NUM_CH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.clear        = bus.clear[0];
    assign bus1.load         = bus.load[0];
    assign bus1.count_enable = bus.count_enable[0];
    assign bus1.count_down   = bus.count_down[0];
    assign bus1.saturate     = bus.saturate[0];
    assign bus1.load_val     = bus.load_val[0];
    assign bus1.rollover_val = bus.rollover_val[0];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one clock step of controls for both channels ({ch1,ch0}) and its expectation
    task automatic step(input logic [1:0] clr, input logic [1:0] ld, input logic [1:0] en,
                        input logic [1:0] dn, input logic [1:0] sat,
                        input logic [7:0] lv, input logic [7:0] rv,
                        input logic [7:0] ecnt, input logic [1:0] eflg, input logic [1:0] ewrp);
        @(negedge clk);
        #1;
        bus.clear        = clr;
        bus.load         = ld;
        bus.count_enable = en;
        bus.count_down   = dn;
        bus.saturate     = sat;
        bus.load_val     = lv;
        bus.rollover_val = rv;
        exp_q.push_back({ecnt, eflg, ewrp, |ewrp, ewrp[0]});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            chk("count_out",     16'(bus.count_out),     16'(e[13:6]));
            chk("rollover_flag", 16'(bus.rollover_flag), 16'(e[5:4]));
            chk("wrap_pulse",    16'(bus.wrap_pulse),    16'(e[3:2]));
            chk("any_wrap",      16'(bus.any_wrap),      16'(e[1]));
            chk("any_wrap_1ch",  16'(bus1.any_wrap),     16'(e[0]));
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_count"}, 16'(bus.count_out), 16'h0);
        chk({tag, "_flag"},  16'(bus.rollover_flag), 16'h0);
        chk({tag, "_wrap"},  16'(bus.wrap_pulse), 16'h0);
        chk({tag, "_any"},   16'(bus.any_wrap), 16'h0);
    endtask

    // idle one edge, then pulse rst between edges and look at the outputs while it is high
    task automatic async_reset_check();
        @(negedge clk);
        #1;
        bus.clear        = '0;
        bus.load         = '0;
        bus.count_enable = '0;
        @(posedge clk);
        #1;
        chk("pre_rst_count", 16'(bus.count_out), 16'h85);
        #1;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.clear        = '0;
        bus.load         = '0;
        bus.count_enable = '0;
        bus.count_down   = '0;
        bus.saturate     = '0;
        bus.load_val     = '0;
        bus.rollover_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        //    clr    ld     en     dn     sat    lv     rv     cnt    flg    wrp
        // ch0 up, wrap, rollover 3
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h03, 8'h01, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h03, 8'h02, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h03, 8'h03, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h03, 8'h00, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h03, 8'h01, 2'b00, 2'b00);
        // ch1 down, wrap, rollover 9, from 0
        step(2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 8'h00, 8'h93, 8'h91, 2'b00, 2'b10);
        step(2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 8'h00, 8'h93, 8'h81, 2'b00, 2'b00);
        // ch0 to 5, then asynchronous reset between edges
        step(2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 8'h05, 8'h9F, 8'h85, 2'b00, 2'b00);
        async_reset_check();
        // ch0 up, saturate, rollover 6, load 12 clamps to 6
        step(2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 8'h0C, 8'h06, 8'h06, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 8'h0C, 8'h06, 8'h06, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 8'h0C, 8'h06, 8'h06, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 8'h0C, 8'h06, 8'h06, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 8'h0C, 8'h06, 8'h06, 2'b01, 2'b00);
        // clear+load+enable on ch0 at 4 while ch1 counts up
        step(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 8'h04, 8'h96, 8'h14, 2'b00, 2'b00);
        step(2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 8'h04, 8'h96, 8'h20, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 8'h04, 8'h96, 8'h30, 2'b00, 2'b00);
        // rollover lowered from 15 to 2 with ch0 at 10
        step(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h0A, 8'h9F, 8'h3A, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h0A, 8'h92, 8'h30, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h0A, 8'h92, 8'h31, 2'b00, 2'b00);
        // rollover 0: up then down, wraps every enabled cycle with flag held high
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h90, 8'h30, 2'b01, 2'b01);
        step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h90, 8'h30, 2'b01, 2'b01);
        step(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 8'h00, 8'h90, 8'h30, 2'b01, 2'b01);
        // down saturate at 0: no pulse
        step(2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 8'h00, 8'h95, 8'h30, 2'b01, 2'b00);
        // down from 12 with rollover lowered to 5 clamps to 5
        step(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h0C, 8'h9F, 8'h3C, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 8'h0C, 8'h95, 8'h35, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 8'h0C, 8'h95, 8'h34, 2'b00, 2'b00);
        // ch0 up / ch1 down together, independent wraps
        step(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 8'h00, 8'h95, 8'h25, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 8'h00, 8'h95, 8'h10, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 8'h00, 8'h95, 8'h01, 2'b10, 2'b00);
        step(2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 8'h00, 8'h95, 8'h92, 2'b00, 2'b10);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
